// File: rtl/mem_arb_pkg.sv
// Shared widths, the memory command record and a small sizing helper
// used by the round-robin memory arbiter and its priority picker.
package mem_arb_pkg;

   // 32 x 8 single-port synchronous memory
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   // One memory command as seen on the arbiter side of the command register
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_cmd_t;

   // Width of a requester index; never below one bit
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Rotating priority encoder: starting at rr_ptr and wrapping modulo
// NUM_REQ, the first asserted request wins. Purely combinational.
module mem_rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   winner,
   output logic               any
);

   logic [PTR_W:0] idx;
   logic           found;

   // Walk the requests from rr_ptr upward and keep the first hit
   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(NUM_REQ)) begin
            idx = idx - (PTR_W+1)'(NUM_REQ);
         end
         if (!found && req[idx[PTR_W-1:0]]) begin
            found                  = 1'b1;
            gnt[idx[PTR_W-1:0]]    = 1'b1;
            winner                 = idx[PTR_W-1:0];
         end
      end
      any = found;
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter in front of a single-port 32x8 synchronous memory.
// One command per cycle is registered onto the memory pins; read data
// comes back two edges after the grant together with a one-hot rvalid.
//
// Handshake: req[i] is the requester's valid, gnt[i] its ready. A
// transfer happens on the posedge where req[i] & gnt[i] is 1; until that
// edge the requester keeps req/req_we/req_addr/req_wdata stable. gnt is a
// function of req and rr_ptr only, so it may be used combinationally by
// the requester without creating a loop.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2   // supported range 2..8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_data_in,
   output logic                       mem_write,
   output logic                       mem_read,
   input  logic [DATA_W-1:0]          mem_data_out
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   winner;
   logic               any;
   mem_cmd_t           sel_cmd;
   mem_cmd_t           cmd_q;
   logic               cmd_vld;
   logic [NUM_REQ-1:0] tag_q1;
   logic [NUM_REQ-1:0] tag_q2;

   mem_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (gnt),
      .winner (winner),
      .any    (any)
   );

   // Route the winner's command fields; gnt is one-hot or zero
   always_comb begin
      sel_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_cmd.we   = req_we[i];
            sel_cmd.addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_cmd.data = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Priority pointer moves just past the winner; idle cycles leave it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (any) begin
         rr_ptr <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + PTR_W'(1);
      end
   end

   // Command register: address always follows a transfer, write data only
   // follows writes, and the valid bit drops on cycles without a transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q   <= '0;
         cmd_vld <= 1'b0;
      end else begin
         cmd_vld <= any;
         if (any) begin
            cmd_q.we   <= sel_cmd.we;
            cmd_q.addr <= sel_cmd.addr;
            if (sel_cmd.we) begin
               cmd_q.data <= sel_cmd.data;
            end
         end
      end
   end

   // A single we bit selects the strobe, so read and write never overlap
   assign mem_write   = cmd_vld &  cmd_q.we;
   assign mem_read    = cmd_vld & ~cmd_q.we;
   assign mem_addr    = cmd_q.addr;
   assign mem_data_in = cmd_q.data;

   // Winner tag follows a read through the command stage and the memory
   // stage; reset flushes any read still in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q1 <= '0;
         tag_q2 <= '0;
      end else begin
         tag_q1 <= (any && !sel_cmd.we) ? gnt : '0;
         tag_q2 <= tag_q1;
      end
   end

   assign rvalid = tag_q2;
   assign rdata  = mem_data_out;

endmodule
